// File: rtl/fullmatch_page_memory_pkg.sv
// Shared constants and types for the BX-paged full-match buffer.
// The page count, index width and the page-capacity rule all live here.
package fullmatch_page_memory_pkg;

    localparam int RESDWIDTH  = 40;
    localparam int MEM_SIZE   = 6;
    localparam int NPAGE_BITS = 4;
    localparam int NPAGES     = 1 << NPAGE_BITS;
    localparam int CNT_W      = 6;
    localparam int ADDR_W     = MEM_SIZE + NPAGE_BITS;
    localparam int DEPTH      = 1 << ADDR_W;

    // The last slot is sacrificed so a full page still fits in a 6-bit count.
    localparam logic [CNT_W-1:0] CAP = CNT_W'((1 << MEM_SIZE) - 1);

    // Position of the active stub index inside a full-match word.
    localparam int FM_IDX_MSB = RESDWIDTH - 1;
    localparam int FM_IDX_LSB = RESDWIDTH - 7;

    typedef logic [RESDWIDTH-1:0]  fm_word_t;
    typedef logic [CNT_W-1:0]      fm_count_t;
    typedef logic [NPAGE_BITS-1:0] page_t;
    typedef logic [ADDR_W-1:0]     fm_addr_t;

    function automatic logic [FM_IDX_MSB-FM_IDX_LSB:0] fm_active_index(input fm_word_t w);
        return w[FM_IDX_MSB:FM_IDX_LSB];
    endfunction

    function automatic page_t page_of(input fm_addr_t a);
        return a[ADDR_W-1 -: NPAGE_BITS];
    endfunction

endpackage

// File: rtl/fullmatch_page_memory_if.sv
// Write and read side signals of the full-match page memory.
// master = match calculator / reader side, slave = the memory.
interface fullmatch_page_memory_if;
    import fullmatch_page_memory_pkg::*;

    logic      new_bx;
    page_t     BX_pipe;
    fm_word_t  data_in;
    logic      write_enable;
    fm_addr_t  read_addr;
    logic      read_enable;
    fm_word_t  data_out;
    fm_count_t number_out;
    logic      overflow;

    modport master (
        output new_bx, BX_pipe, data_in, write_enable, read_addr, read_enable,
        input  data_out, number_out, overflow
    );

    modport slave (
        input  new_bx, BX_pipe, data_in, write_enable, read_addr, read_enable,
        output data_out, number_out, overflow
    );
endinterface

// File: rtl/fullmatch_page_memory_sdp_ram_2clk.sv
// Simple dual-port read-first RAM, two-stage read pipeline (RAM reg + output reg).
// Both read stages advance only while rd_en is high.
module sdp_ram_2clk #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] ram_q;
    logic             ram_valid_q;
    logic [WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reading at the launch edge makes a same-cycle write invisible (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q       <= '0;
            ram_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (rd_en) begin
            ram_q       <= mem[rd_addr];
            ram_valid_q <= 1'b1;
            if (ram_valid_q) begin
                out_q <= ram_q;
            end
        end
    end

    assign rd_data = out_q;
endmodule

// File: rtl/fullmatch_page_memory.sv
// BX-paged full-match buffer: one page per BX, per-page entry counters,
// sticky-per-BX overflow flag and a 2-cycle read path.
module fullmatch_page_memory
    import fullmatch_page_memory_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    fullmatch_page_memory_if.slave  bus
);
    fm_count_t count_q [NPAGES];
    fm_count_t count_d [NPAGES];
    page_t     wr_page_q, wr_page_d;
    logic      overflow_q, overflow_d;

    page_t     eff_page;
    fm_count_t eff_count;
    logic      wr_ok;

    // A new_bx write lands in the freshly opened page at index 0.
    always_comb begin
        eff_page   = bus.new_bx ? bus.BX_pipe : wr_page_q;
        eff_count  = bus.new_bx ? '0 : count_q[wr_page_q];
        wr_ok      = bus.write_enable && (eff_count < CAP);
        wr_page_d  = eff_page;
        overflow_d = bus.new_bx ? 1'b0 : overflow_q;
        if (bus.write_enable && !wr_ok) begin
            overflow_d = 1'b1;
        end
        for (int i = 0; i < NPAGES; i++) begin
            count_d[i] = count_q[i];
            if (bus.new_bx && bus.BX_pipe == NPAGE_BITS'(i)) begin
                count_d[i] = '0;
            end
            if (wr_ok && eff_page == NPAGE_BITS'(i)) begin
                count_d[i] = eff_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_page_q  <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NPAGES; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            wr_page_q  <= wr_page_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < NPAGES; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    sdp_ram_2clk #(
        .WIDTH (RESDWIDTH),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !rst),
        .wr_addr ({eff_page, eff_count[MEM_SIZE-1:0]}),
        .wr_data (bus.data_in),
        .rd_en   (bus.read_enable),
        .rd_addr (bus.read_addr),
        .rd_data (bus.data_out)
    );

    assign bus.number_out = count_q[page_of(bus.read_addr)];
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fullmatch_page_memory.sv
// Bench for fullmatch_page_memory: vector table plus hand-written sequences,
// read results checked through a launch/complete scoreboard queue.
module tb_fullmatch_page_memory;
    import fullmatch_page_memory_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fullmatch_page_memory_if bus();

    fullmatch_page_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    fm_word_t  mdl_mem [DEPTH];
    fm_count_t mdl_cnt [NPAGES];
    page_t     mdl_page;
    logic      mdl_ovf;
    fm_word_t  mdl_dout;
    logic      mdl_s1v;
    fm_word_t  sb_q [$];

    typedef struct {
        logic      nb;
        page_t     bx;
        logic      we;
        fm_word_t  din;
        logic      re;
        fm_addr_t  raddr;
        fm_count_t exp_num;
        logic      exp_ovf;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic nb, input page_t bx, input logic we, input fm_word_t din,
                         input logic re, input fm_addr_t raddr);
        bus.new_bx       = nb;
        bus.BX_pipe      = bx;
        bus.write_enable = we;
        bus.data_in      = din;
        bus.read_enable  = re;
        bus.read_addr    = raddr;
    endtask

    // One clock: update the reference model at the edge, compare at edge+1.
    task automatic step();
        fm_word_t  launch;
        fm_word_t  exp_rd;
        logic      done;
        page_t     pg;
        fm_count_t cc;
        launch = mdl_mem[bus.read_addr];
        exp_rd = '0;
        done   = 1'b0;
        @(posedge clk);
        if (rst) begin
            foreach (mdl_cnt[i]) mdl_cnt[i] = '0;
            mdl_page = '0;
            mdl_ovf  = 1'b0;
            mdl_dout = '0;
            mdl_s1v  = 1'b0;
            sb_q.delete();
        end else begin
            pg = bus.new_bx ? bus.BX_pipe : mdl_page;
            cc = bus.new_bx ? 6'd0 : mdl_cnt[pg];
            if (bus.new_bx) begin
                mdl_page    = bus.BX_pipe;
                mdl_cnt[pg] = '0;
                mdl_ovf     = 1'b0;
            end
            if (bus.write_enable) begin
                if (cc < 6'd63) begin
                    mdl_mem[{pg, cc}] = bus.data_in;
                    mdl_cnt[pg]       = cc + 6'd1;
                end else begin
                    mdl_ovf = 1'b1;
                end
            end
            if (bus.read_enable) begin
                if (mdl_s1v && sb_q.size() > 0) begin
                    exp_rd   = sb_q.pop_front();
                    mdl_dout = exp_rd;
                    done     = 1'b1;
                end
                sb_q.push_back(launch);
                mdl_s1v = 1'b1;
            end
        end
        #1;
        if (done) begin
            check("rd_data", bus.data_out, exp_rd);
            $display("[TB] read complete: data_out=%h expected=%h", bus.data_out, exp_rd);
        end else begin
            check("dout_hold", bus.data_out, mdl_dout);
        end
        check("number_out", bus.number_out, mdl_cnt[page_of(bus.read_addr)]);
        check("overflow", bus.overflow, mdl_ovf);
    endtask

    initial begin
        foreach (mdl_mem[i]) mdl_mem[i] = '0;
        foreach (mdl_cnt[i]) mdl_cnt[i] = '0;
        mdl_page = '0; mdl_ovf = 1'b0; mdl_dout = '0; mdl_s1v = 1'b0;

        vecs[0] = '{1'b1, 4'd3, 1'b0, 40'h0, 1'b0, {4'd3, 6'd0}, 6'd0, 1'b0};
        for (int i = 0; i < 5; i++)
            vecs[1+i] = '{1'b0, 4'd0, 1'b1, 40'hA0 + 40'(i), 1'b0, {4'd3, 6'd0}, 6'(i + 1), 1'b0};
        for (int i = 0; i < 5; i++)
            vecs[6+i] = '{1'b0, 4'd0, 1'b0, 40'h0, 1'b1, {4'd3, 6'(i)}, 6'd5, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 1'b0, 40'h0, 1'b1, {4'd3, 6'd0}, 6'd5, 1'b0};

        // Reset
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("reset_num", bus.number_out, 6'd0);
        check("reset_ovf", bus.overflow, 1'b0);
        check("reset_dout", bus.data_out, 40'h0);

        // Page 3: five writes then back-to-back reads
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].nb, vecs[i].bx, vecs[i].we, vecs[i].din, vecs[i].re, vecs[i].raddr);
            step();
            check("vec_num", bus.number_out, vecs[i].exp_num);
            check("vec_ovf", bus.overflow, vecs[i].exp_ovf);
        end
        check("p3_last_read", bus.data_out, 40'hA4);

        // new_bx with a write in the same cycle
        drive(1, 4'd7, 1, 40'h55, 0, {4'd7, 6'd0});
        step();
        check("p7_count", bus.number_out, 6'd1);
        bus.new_bx = 1'b0; bus.write_enable = 1'b0;
        bus.read_addr = {4'd3, 6'd0};
        #1;
        check("p3_kept", bus.number_out, 6'd5);
        drive(0, 0, 0, 0, 1, {4'd7, 6'd0});
        step(); step();
        check("p7_idx0", bus.data_out, 40'h55);

        // Same-cycle read and write of {3,2}: read-first
        drive(1, 4'd3, 1, 40'hB0, 0, 0);              step();
        drive(0, 0, 1, 40'hB1, 0, 0);                 step();
        drive(0, 0, 1, 40'hB2, 1, {4'd3, 6'd2});      step();
        drive(0, 0, 0, 0, 1, {4'd3, 6'd2});           step();
        check("rw_old", bus.data_out, 40'hA2);
        step();
        check("rw_new", bus.data_out, 40'hB2);

        // Stall read_enable for three cycles mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, {4'd3, 6'(i)});
            step();
        end
        check("pre_stall", bus.data_out, 40'hB1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, {4'd3, 6'd4});
            step();
            check("stall_hold", bus.data_out, 40'hB1);
        end
        drive(0, 0, 0, 0, 1, {4'd3, 6'd3});
        step();
        check("resume", bus.data_out, 40'hB2);
        step();
        check("stale_read", bus.data_out, 40'hA3);

        // Fill page 5 to capacity and beyond
        drive(1, 4'd5, 0, 0, 0, {4'd5, 6'd0});
        step();
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, 1, 40'h100 + 40'(i), 0, {4'd5, 6'd0});
            step();
            if (i == 62) begin
                check("full_num", bus.number_out, 6'd63);
                check("full_no_ovf", bus.overflow, 1'b0);
            end
        end
        check("ovf_set", bus.overflow, 1'b1);
        check("ovf_num_hold", bus.number_out, 6'd63);
        drive(0, 0, 0, 0, 1, {4'd5, 6'd62});
        step(); step();
        check("p5_last", bus.data_out, 40'h13E);
        drive(1, 4'd9, 0, 0, 0, {4'd9, 6'd0});
        step();
        check("ovf_clear", bus.overflow, 1'b0);
        check("p9_empty", bus.number_out, 6'd0);
        bus.new_bx = 1'b0;
        bus.read_addr = {4'd5, 6'd0};
        #1;
        check("p5_kept", bus.number_out, 6'd63);

        // Reset in the middle of a BX
        drive(1, 4'd11, 0, 0, 0, {4'd11, 6'd0});
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 40'hD0 + 40'(i), 0, {4'd11, 6'd0});
            step();
        end
        check("p11_num", bus.number_out, 6'd4);
        drive(0, 0, 0, 0, 0, {4'd11, 6'd0});
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_p11", bus.number_out, 6'd0);
        check("rst_dout", bus.data_out, 40'h0);
        check("rst_ovf", bus.overflow, 1'b0);
        drive(0, 0, 1, 40'hCC, 0, {4'd0, 6'd0});
        step();
        check("post_rst_p0", bus.number_out, 6'd1);
        drive(0, 0, 0, 0, 1, {4'd0, 6'd0});
        step(); step();
        check("post_rst_data", bus.data_out, 40'hCC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fullmatch_page_memory.md
Name: fullmatch_page_memory

Overview:
- BX-paged buffer for full matches, directly upstream of the per-layer full-match reader/merger.
- Match calculator writes one full match per cycle into the page of the current BX and keeps a per-page entry count.
- Reader side takes {page, index} addresses and gets data back with a fixed 2-cycle latency.
- number_out reports the entry count of the page currently addressed by the reader.

Parameters:
- RESDWIDTH, 40, width of one full-match word.
- MEM_SIZE, `MEM_SIZE (from constants), index bits per page; legal range 1..6.
- NPAGE_BITS, 4, page-select bits; 16 pages.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- new_bx  in  1  one-cycle pulse marking the start of a BX.
- BX_pipe  in  4  BX number of the BX that starts at new_bx.
- data_in  in  RESDWIDTH  full match to store.
- write_enable  in  1  store data_in this cycle.
- read_addr  in  MEM_SIZE+NPAGE_BITS  {page, index}.
- read_enable  in  1  launch a read.
- data_out  out  RESDWIDTH  read data, 2 cycles after the read is launched.
- number_out  out  6  entry count of page read_addr[top NPAGE_BITS]; combinational.
- overflow  out  1  sticky per BX; set when a write is dropped.

Behaviour:
- Reset (rst=1 at posedge; takes priority over everything):
  - all 16 page counters = 0, wr_page = 0, overflow = 0.
  - data_out = 0, and the read pipeline valid/data regs are cleared.
  - memory contents are not cleared.
- Write side:
  - wr_page register selects the page written.
  - On new_bx:
    - wr_page <= BX_pipe.
    - count[BX_pipe] <= 0.
    - overflow <= 0.
  - Write address = {current write page, count[current write page][MEM_SIZE-1:0]}.
  - On write_enable with count < CAP, where CAP = 2^MEM_SIZE − 1 so the count fits in 6 bits:
    - word written.
    - count incremented.
  - On write_enable with count == CAP:
    - word dropped, count holds.
    - overflow <= 1.
- Simultaneous new_bx and write_enable in the same cycle:
  - the write goes to page BX_pipe, index 0.
  - count[BX_pipe] becomes 1, not 0.
  - overflow is cleared unless that same write overflows, which is impossible at count 0.
- Counts of the other pages are untouched by new_bx. A page keeps its count until its BX number comes round again, 16 BX later.
- Read side:
  - Address registered at the posedge where read_enable = 1 (cycle 1).
  - RAM output registered at the next posedge (cycle 2).
  - data_out is valid after posedge 2 and holds until the next read completes.
  - read_enable = 0: the pipeline does not advance and data_out holds its value.
  - Back-to-back reads: one result per cycle.
- Same-address read and write in the same cycle: read-first; old contents returned.
- Reading an index ≥ count returns stale contents. The reader is responsible for gating with number_out.
- number_out = count[read_addr page field]:
  - pure mux over the registered counters, zero latency.
  - a write in cycle N becomes visible from cycle N+1.
- MEM_SIZE < 6: number_out is zero-extended to 6 bits.

Decomposition:
- Shared package / constants header holds:
  - MEM_SIZE, NPAGE_BITS.
  - CAP derivation.
  - full-match word width RESDWIDTH and its field ranges (active-index MSB/LSB).
- Sub-module sdp_ram_2clk: generic simple-dual-port, read-first RAM with registered address and registered output, parameterised by width and depth.
- Counters, write-page logic and overflow flag live in fullmatch_page_memory itself.

Test Plan:
- rst, then new_bx with BX_pipe=3; write 5 words 0xA0..0xA4 → number_out=5 when read_addr page=3. Reads of idx 0..4 return 0xA0..0xA4 with 2-cycle latency, back-to-back.
- new_bx with BX_pipe=7 and write_enable in the same cycle, data 0x55 → word lands at {7,0}, count[7]=1, count[3] still 5.
- MEM_SIZE=6: 64 writes into one page → number_out=63, overflow=1 from the cycle after the 64th write. The next new_bx clears overflow and the new page count is 0.
- Read {3,2} while the write targets {3,2} in the same cycle → data_out = old word. A second read 1 cycle later returns the new word.
- read_enable deasserted for 3 cycles mid-stream → data_out holds the last value, and the pipeline resumes without loss.
- rst asserted mid-BX after 4 writes → next cycle all counts=0, data_out=0, overflow=0. A subsequent write goes to page 0, index 0.
